// File: rtl/regfile_pkg.sv
// Shared defaults for the multiport register file and its busy scoreboard.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NUM_RD_DEF = 2;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy flags: a new producer sets, write-back clears, set beats clear.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] adr,
  input  logic [ADDR_W-1:0]        awr,
  input  logic                     wr_en,
  input  logic                     set_busy,
  input  logic [ADDR_W-1:0]        adr_busy,
  output logic [NUM_RD-1:0]        busy
);

  localparam int DEPTH    = depth_of(ADDR_W);
  localparam bit HAS_ZERO = (ZERO_REG != 0);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // Register 0 never has a producer when it is hard-wired to zero.
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < DEPTH; r++) begin
      if (HAS_ZERO && r == 0) begin
        busy_d[r] = 1'b0;
      end else if (set_busy && adr_busy == ADDR_W'(r)) begin
        busy_d[r] = 1'b1;
      end else if (wr_en && awr == ADDR_W'(r)) begin
        busy_d[r] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // A write retiring this cycle releases the operand: the bypass supplies it.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_lookup
    logic [ADDR_W-1:0] rd_adr;
    assign rd_adr  = adr[k*ADDR_W +: ADDR_W];
    assign busy[k] = busy_q[rd_adr] & ~(wr_en && awr == rd_adr);
  end

endmodule

// File: rtl/regfile_multiport.sv
// Register array with NUM_RD registered read ports, write-to-read bypass and busy scoreboard.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] Adr,
  output logic [NUM_RD*DATA_W-1:0] Dout,
  output logic [NUM_RD-1:0]        Busy,
  input  logic [ADDR_W-1:0]        Awr,
  input  logic [DATA_W-1:0]        Din,
  input  logic                     WrEn,
  input  logic                     SetBusy,
  input  logic [ADDR_W-1:0]        AdrBusy
);

  localparam int DEPTH    = depth_of(ADDR_W);
  localparam bit HAS_ZERO = (ZERO_REG != 0);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_ok;

  assign wr_ok = WrEn && !(HAS_ZERO && Awr == '0);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int r = 0; r < DEPTH; r++) begin
        mem[r] <= '0;
      end
    end else if (wr_ok) begin
      mem[Awr] <= Din;
    end
  end

  // Zero register first, then same-cycle bypass, then the stored value.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] rd_adr;
    logic [DATA_W-1:0] rd_q;

    assign rd_adr = Adr[k*ADDR_W +: ADDR_W];

    always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
        rd_q <= '0;
      end else if (HAS_ZERO && rd_adr == '0) begin
        rd_q <= '0;
      end else if (WrEn && Awr == rd_adr) begin
        rd_q <= Din;
      end else begin
        rd_q <= mem[rd_adr];
      end
    end

    assign Dout[k*DATA_W +: DATA_W] = rd_q;
  end

  regfile_scoreboard #(
    .ADDR_W  (ADDR_W),
    .NUM_RD  (NUM_RD),
    .ZERO_REG(ZERO_REG)
  ) u_scoreboard (
    .clk     (Clk),
    .rst_n   (Rst_n),
    .adr     (Adr),
    .awr     (Awr),
    .wr_en   (WrEn),
    .set_busy(SetBusy),
    .adr_busy(AdrBusy),
    .busy    (Busy)
  );

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for two configurations: default 32x32/2 ports with zero register, and 8x64/4 ports without.
module tb_regfile_multiport;

  logic clk;
  logic rst_n;
  bit   cmp_en;
  int   errors;
  int   checks;

  // Instance stimulus kept as plain arrays so the model reads the same values.
  int          in_adr [2][4];
  int          in_awr [2];
  logic [63:0] in_din [2];
  bit          in_we  [2];
  bit          in_set [2];
  int          in_ab  [2];

  logic [9:0]   a_adr;
  logic [63:0]  a_dout;
  logic [1:0]   a_busy;
  logic [4:0]   a_awr;
  logic [31:0]  a_din;
  logic         a_we;
  logic         a_set;
  logic [4:0]   a_ab;

  logic [11:0]  b_adr;
  logic [255:0] b_dout;
  logic [3:0]   b_busy;
  logic [2:0]   b_awr;
  logic [63:0]  b_din;
  logic         b_we;
  logic         b_set;
  logic [2:0]   b_ab;

  assign a_adr = {5'(in_adr[0][1]), 5'(in_adr[0][0])};
  assign a_awr = 5'(in_awr[0]);
  assign a_din = in_din[0][31:0];
  assign a_we  = in_we[0];
  assign a_set = in_set[0];
  assign a_ab  = 5'(in_ab[0]);

  assign b_adr = {3'(in_adr[1][3]), 3'(in_adr[1][2]), 3'(in_adr[1][1]), 3'(in_adr[1][0])};
  assign b_awr = 3'(in_awr[1]);
  assign b_din = in_din[1];
  assign b_we  = in_we[1];
  assign b_set = in_set[1];
  assign b_ab  = 3'(in_ab[1]);

  regfile_multiport #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) dut_a (
    .Clk(clk), .Rst_n(rst_n), .Adr(a_adr), .Dout(a_dout), .Busy(a_busy),
    .Awr(a_awr), .Din(a_din), .WrEn(a_we), .SetBusy(a_set), .AdrBusy(a_ab)
  );

  regfile_multiport #(.DATA_W(64), .ADDR_W(3), .NUM_RD(4), .ZERO_REG(0)) dut_b (
    .Clk(clk), .Rst_n(rst_n), .Adr(b_adr), .Dout(b_dout), .Busy(b_busy),
    .Awr(b_awr), .Din(b_din), .WrEn(b_we), .SetBusy(b_set), .AdrBusy(b_ab)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: register contents, pending-producer flags, expected read data.
  logic [63:0] m_mem  [2][8*4];
  bit          m_busy [2][8*4];
  logic [63:0] m_exp  [2][4];

  function automatic int nr(input int i);
    return (i == 0) ? 2 : 4;
  endfunction

  function automatic bit zr(input int i);
    return (i == 0);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int r = 0; r < 32; r++) begin
        m_mem[i][r]  = '0;
        m_busy[i][r] = 1'b0;
      end
      for (int k = 0; k < 4; k++) m_exp[i][k] = '0;
    end
  endfunction

  function automatic void model_edge(input int i);
    logic [63:0] mask;
    int a;
    mask = (i == 0) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    for (int k = 0; k < nr(i); k++) begin
      a = in_adr[i][k];
      if (zr(i) && a == 0)                   m_exp[i][k] = '0;
      else if (in_we[i] && in_awr[i] == a)   m_exp[i][k] = in_din[i] & mask;
      else                                   m_exp[i][k] = m_mem[i][a];
    end
    if (in_we[i] && !(zr(i) && in_awr[i] == 0)) m_mem[i][in_awr[i]] = in_din[i] & mask;
    if (in_we[i])  m_busy[i][in_awr[i]] = 1'b0;
    if (in_set[i]) m_busy[i][in_ab[i]]  = 1'b1;
    if (zr(i))     m_busy[i][0]         = 1'b0;
  endfunction

  function automatic bit exp_busy(input int i, input int k);
    int a;
    a = in_adr[i][k];
    return m_busy[i][a] && !(in_we[i] && in_awr[i] == a);
  endfunction

  function automatic logic [63:0] dout_of(input int i, input int k);
    return (i == 0) ? {32'h0, a_dout[k*32 +: 32]} : b_dout[k*64 +: 64];
  endfunction

  function automatic bit busy_of(input int i, input int k);
    return (i == 0) ? a_busy[k] : b_busy[k];
  endfunction

  always @(negedge rst_n) model_reset();

  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      model_edge(0);
      model_edge(1);
    end
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every cycle: registered data and combinational busy against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        for (int k = 0; k < nr(i); k++) begin
          check_output($sformatf("model dout i%0d p%0d", i, k), dout_of(i, k), m_exp[i][k]);
          check_output($sformatf("model busy i%0d p%0d", i, k), 64'(busy_of(i, k)), 64'(exp_busy(i, k)));
        end
      end
    end
  end

  logic [3:0] last_busy;

  // Drive one cycle of inputs on instance i, record Busy before the edge, return #1 after it.
  task automatic apply_stimulus(input int i, input int a0, input int a1, input int a2, input int a3,
                                input bit we = 0, input int awr = 0, input logic [63:0] din = '0,
                                input bit set = 0, input int ab = 0);
    in_adr[i][0] = a0; in_adr[i][1] = a1; in_adr[i][2] = a2; in_adr[i][3] = a3;
    in_we[i]  = we;  in_awr[i] = awr; in_din[i] = din;
    in_set[i] = set; in_ab[i]  = ab;
    @(negedge clk);
    last_busy = (i == 0) ? {2'b00, a_busy} : b_busy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cmp_en = 1'b0;
    rst_n  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 4; k++) in_adr[i][k] = 0;
      in_awr[i] = 0; in_din[i] = '0; in_we[i] = 0; in_set[i] = 0; in_ab[i] = 0;
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_output("reset dout a", a_dout, 64'h0);
    check_output("reset busy a", 64'(a_busy), 64'h0);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // Basic write/read
    apply_stimulus(0, 0, 0, 0, 0, 1, 5, 64'h1234_5678);
    apply_stimulus(0, 0, 0, 0, 0, 1, 31, 64'hFFFF_FFFF);
    apply_stimulus(0, 5, 31, 0, 0);
    check_output("basic dout0", dout_of(0, 0), 64'h1234_5678);
    check_output("basic dout1", dout_of(0, 1), 64'hFFFF_FFFF);

    // Zero register ignores writes, including through the bypass
    apply_stimulus(0, 0, 0, 0, 0, 1, 0, 64'hDEAD_BEEF);
    check_output("zero bypass dout0", dout_of(0, 0), 64'h0);
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("zero read dout1", dout_of(0, 1), 64'h0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, '0, 1, 0);
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("zero busy", 64'(last_busy), 64'h0);

    // Bypass
    apply_stimulus(0, 0, 0, 0, 0, 1, 7, 64'h1);
    apply_stimulus(0, 7, 7, 0, 0, 1, 7, 64'hA5A5_A5A5);
    check_output("bypass dout0", dout_of(0, 0), 64'hA5A5_A5A5);
    check_output("bypass dout1", dout_of(0, 1), 64'hA5A5_A5A5);

    // Scoreboard on r9
    apply_stimulus(0, 9, 0, 0, 0, 0, 0, '0, 1, 9);
    check_output("sb busy set cycle", 64'(last_busy), 64'h0);
    apply_stimulus(0, 9, 0, 0, 0);
    check_output("sb busy n+1", 64'(last_busy), 64'h1);
    apply_stimulus(0, 9, 0, 0, 0);
    check_output("sb busy n+2", 64'(last_busy), 64'h1);
    apply_stimulus(0, 9, 0, 0, 0, 1, 9, 64'h55);
    check_output("sb busy release", 64'(last_busy), 64'h0);
    check_output("sb dout0", dout_of(0, 0), 64'h55);
    apply_stimulus(0, 9, 0, 0, 0);
    check_output("sb busy after", 64'(last_busy), 64'h0);

    // Set and clear of r3 on the same edge: set wins
    apply_stimulus(0, 3, 3, 0, 0, 0, 0, '0, 1, 3);
    apply_stimulus(0, 3, 3, 0, 0, 1, 3, 64'h77, 1, 3);
    check_output("collision busy", 64'(last_busy), 64'h0);
    check_output("collision dout", dout_of(0, 0), 64'h77);
    apply_stimulus(0, 3, 3, 0, 0);
    check_output("collision busy after", 64'(last_busy), 64'h3);

    // Asynchronous reset mid-run; a write on a reset-low edge is dropped
    apply_stimulus(0, 5, 5, 0, 0, 0, 0, '0, 1, 5);
    in_set[0] = 0;
    #1;
    check_output("pre-reset busy", 64'(a_busy), 64'h3);
    check_output("pre-reset dout1", dout_of(0, 1), 64'h1234_5678);
    rst_n = 1'b0;
    #1;
    check_output("async reset dout", a_dout, 64'h0);
    check_output("async reset busy", 64'(a_busy), 64'h0);
    apply_stimulus(0, 5, 5, 0, 0, 1, 5, 64'hBAD);
    rst_n = 1'b1;
    apply_stimulus(0, 5, 5, 0, 0);
    check_output("post-reset dout0", dout_of(0, 0), 64'h0);
    check_output("post-reset busy", 64'(last_busy), 64'h0);

    // Wide configuration, r0 ordinary
    apply_stimulus(1, 0, 0, 0, 0, 1, 0, 64'h0123_4567_89AB_CDEF);
    for (int k = 0; k < 4; k++)
      check_output($sformatf("wide bypass p%0d", k), dout_of(1, k), 64'h0123_4567_89AB_CDEF);
    apply_stimulus(1, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++)
      check_output($sformatf("wide read p%0d", k), dout_of(1, k), 64'h0123_4567_89AB_CDEF);
    apply_stimulus(1, 0, 0, 0, 0, 1, 7, 64'hFEDC_BA98_7654_3210);
    apply_stimulus(1, 7, 0, 7, 0);
    check_output("wide mix p0", dout_of(1, 0), 64'hFEDC_BA98_7654_3210);
    check_output("wide mix p1", dout_of(1, 1), 64'h0123_4567_89AB_CDEF);
    check_output("wide mix p2", dout_of(1, 2), 64'hFEDC_BA98_7654_3210);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, '0, 1, 0);
    apply_stimulus(1, 0, 0, 0, 0);
    check_output("wide r0 busy", 64'(last_busy), 64'hF);
    apply_stimulus(1, 0, 0, 0, 0, 1, 0, 64'h1);
    check_output("wide r0 release", 64'(last_busy), 64'h0);
    check_output("wide r0 dout3", dout_of(1, 3), 64'h1);
    apply_stimulus(1, 0, 7, 0, 0);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
